power_db_converter: RTL

POWER_DB_CONVERTER -- requirements
Module: power_db_converter

---
 rtl/power_db_converter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/power_db_converter.sv
// Power-to-dB converter: Mitchell log2 approximation scaled to dB, per-channel
// offset and saturation. Optional peak hold under POWER_DB_PEAK_HOLD_EN.
module power_db_converter #(
  parameter int DW        = 32,
  parameter int CH        = 4,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 16,
  localparam int CW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [CW-1:0]           s_ch,
  input  logic [DW-1:0]           s_power,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CW-1:0]           m_ch,
  output logic signed [OUT_W-1:0] m_db,
  output logic                    m_zero,
  input  logic                    cfg_we,
  input  logic [CW-1:0]           cfg_ch,
`ifdef POWER_DB_PEAK_HOLD_EN
  input  logic [CW-1:0]           peak_ch,
  input  logic                    peak_clr,
  output logic signed [OUT_W-1:0] peak_db,
`endif
  input  logic signed [OUT_W-1:0] cfg_offset
);

  localparam int PBW = (DW > 1) ? $clog2(DW) : 1;
  localparam int LW  = PBW + FRAC_BITS;
  localparam int PW  = LW + 19;
  localparam int DDW = PW - 16;
  localparam int SW  = ((DDW > OUT_W) ? DDW : OUT_W) + 2;

  localparam logic [PW-1:0] K   = PW'(197283);
  localparam logic [PW-1:0] RND = PW'(32768);

  localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [SW-1:0]    SMAX = SW'(OMAX);
  localparam logic signed [SW-1:0]    SMIN = SW'(OMIN);

  logic en;
  logic v1_q, v2_q, v3_q, v4_q;
  logic z2_q, z3_q, z4_q;
  logic [CW-1:0] c1_q, c2_q, c3_q, c4_q;
  logic [DW-1:0] p1_q;
  logic [LW-1:0] l2_q;
  logic [DDW-1:0] d3_q;
  logic signed [OUT_W-1:0] db4_q;
  logic signed [OUT_W-1:0] off_q [CH];

  logic [CW-1:0] cin;
  logic [PBW-1:0] msb;
  logic [DW+FRAC_BITS-1:0] ext;
  logic [FRAC_BITS-1:0] frac;
  logic [PW-1:0] prod;
  logic signed [SW-1:0] sum;
  logic signed [OUT_W-1:0] db_d;

  assign en      = m_ready || !v4_q;
  assign s_ready = en;
  assign m_valid = v4_q;
  assign m_ch    = c4_q;
  assign m_db    = db4_q;
  assign m_zero  = z4_q;

  assign cin = (32'(s_ch) < CH) ? s_ch : '0;

  // Normalise so the leading one falls off the top; the bits below it remain.
  always_comb begin
    msb = '0;
    for (int i = 0; i < DW; i++) begin
      if (p1_q[i]) msb = PBW'(i);
    end
    ext  = {p1_q, {FRAC_BITS{1'b0}}} << (PBW'(DW - 1) - msb);
    frac = FRAC_BITS'(ext >> (DW - 1));
  end

  assign prod = PW'(l2_q) * K + RND;

  always_comb begin
    sum = $signed(SW'(d3_q)) + SW'(off_q[c3_q]);
    if (z3_q) begin
      db_d = OMIN;
    end else if (sum > SMAX) begin
      db_d = OMAX;
    end else if (sum < SMIN) begin
      db_d = OMIN;
    end else begin
      db_d = OUT_W'(sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      z2_q  <= 1'b0;
      z3_q  <= 1'b0;
      z4_q  <= 1'b0;
      c1_q  <= '0;
      c2_q  <= '0;
      c3_q  <= '0;
      c4_q  <= '0;
      p1_q  <= '0;
      l2_q  <= '0;
      d3_q  <= '0;
      db4_q <= '0;
    end else if (en) begin
      v1_q  <= s_valid;
      c1_q  <= cin;
      p1_q  <= s_power;
      v2_q  <= v1_q;
      c2_q  <= c1_q;
      z2_q  <= (p1_q == '0);
      l2_q  <= {msb, frac};
      v3_q  <= v2_q;
      c3_q  <= c2_q;
      z3_q  <= z2_q;
      d3_q  <= DDW'(prod >> 16);
      v4_q  <= v3_q;
      c4_q  <= c3_q;
      z4_q  <= z3_q;
      db4_q <= db_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) off_q[i] <= '0;
    end else if (cfg_we && (32'(cfg_ch) < CH)) begin
      off_q[cfg_ch] <= cfg_offset;
    end
  end

`ifdef POWER_DB_PEAK_HOLD_EN
  logic signed [OUT_W-1:0] peak_q [CH];
  logic upd;

  assign upd     = v4_q && m_ready && !z4_q;
  assign peak_db = (32'(peak_ch) < CH) ? peak_q[peak_ch] : OMIN;

  // A clear coinciding with an update of the same channel takes the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) peak_q[i] <= OMIN;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (upd && 32'(c4_q) == i &&
            (db4_q > peak_q[i] || (peak_clr && 32'(peak_ch) == i))) begin
          peak_q[i] <= db4_q;
        end else if (peak_clr && 32'(peak_ch) == i) begin
          peak_q[i] <= OMIN;
        end
      end
    end
  end
`endif

endmodule
